// File: rtl/arp_tx_pkg.sv
// Shared Ethernet/ARP constants and the one-hot frame-builder state encoding.
package arp_tx_pkg;

    localparam logic [15:0] ETH_TYPE_ARP = 16'h0806;
    localparam logic [15:0] ARP_HTYPE    = 16'h0001;
    localparam logic [15:0] ARP_PTYPE    = 16'h0800;
    localparam logic [15:0] ARP_OP_REQ   = 16'h0001;
    localparam logic [15:0] ARP_OP_REPLY = 16'h0002;
    localparam logic [7:0]  ARP_HLEN     = 8'd6;
    localparam logic [7:0]  ARP_PLEN     = 8'd4;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    localparam int MIN_PAYLOAD  = 46;
    localparam int PREAMBLE_LEN = 8;
    localparam int ETH_HEAD_LEN = 14;
    localparam int ARP_DATA_LEN = 28;
    localparam int PAD_LEN      = MIN_PAYLOAD - ARP_DATA_LEN;
    localparam int FCS_LEN      = 4;

    localparam logic [31:0] CRC32_POLY = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;

    typedef enum logic [6:0] {
        ST_IDLE     = 7'b000_0001,
        ST_PREAMBLE = 7'b000_0010,
        ST_ETH_HEAD = 7'b000_0100,
        ST_ARP_DATA = 7'b000_1000,
        ST_PAD      = 7'b001_0000,
        ST_FCS      = 7'b010_0000,
        ST_IFG      = 7'b100_0000
    } tx_state_t;

    // Terminal value of the shared byte counter for a segment of len bytes.
    function automatic logic [6:0] last_idx(input int len);
        return 7'(len - 1);
    endfunction

endpackage

// File: rtl/arp_tx_crc32_d8.sv
// Reflected CRC-32 (0xEDB88320), one byte per clock, LSB first.
// Kept generic so the UDP transmit path can reuse it.
module crc32_d8
    import arp_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        crc_en,
    input  logic        crc_clr,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] crc_q;
    logic [31:0] crc_next;

    always_comb begin
        crc_next = crc_q;
        for (int i = 0; i < 8; i++) begin
            crc_next = {1'b0, crc_next[31:1]} ^ (CRC32_POLY & {32{crc_next[0] ^ data[i]}});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= CRC32_INIT;
        end else if (crc_clr) begin
            crc_q <= CRC32_INIT;
        end else if (crc_en) begin
            crc_q <= crc_next;
        end
    end

    assign crc_out = crc_q;

endmodule

// File: rtl/arp_tx.sv
// ARP request/reply framer driving GMII TX: preamble, Ethernet header,
// ARP payload, zero pad to 60 bytes and FCS, followed by an enforced IFG.
//
// state       | meaning
// ------------+-----------------------------------------------
// ST_IDLE     | waiting for arp_tx_en; latches type/MAC/IP
// ST_PREAMBLE | 7x 0x55 then SFD 0xD5
// ST_ETH_HEAD | 14-byte Ethernet II header
// ST_ARP_DATA | 28-byte ARP payload
// ST_PAD      | zero fill up to the 60-byte minimum frame
// ST_FCS      | inverted CRC, low byte first
// ST_IFG      | tx_en low for IFG_CYCLES, tx_done in the first cycle
module arp_tx
    import arp_tx_pkg::*;
#(
    parameter logic [47:0] BOARD_MAC  = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP   = {8'd192, 8'd168, 8'd1, 8'd10},
    parameter int          IFG_CYCLES = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arp_tx_en,
    input  logic        arp_tx_type,
    input  logic [47:0] des_mac,
    input  logic [31:0] des_ip,
    output logic        gmii_tx_en,
    output logic [7:0]  gmii_txd,
    output logic        tx_done,
    output logic        busy
);

    tx_state_t   state;
    logic [6:0]  cnt;
    logic        op_reply;
    logic [47:0] mac_q;
    logic [31:0] ip_q;

    logic [111:0] eth_hdr;
    logic [223:0] arp_pl;
    logic [7:0]   eth_bytes [ETH_HEAD_LEN];
    logic [7:0]   arp_bytes [ARP_DATA_LEN];
    logic [7:0]   cur_byte;
    logic [31:0]  fcs;
    logic [31:0]  crc_out;
    logic         crc_en;
    logic         crc_clr;
    logic [6:0]   seg_last;
    tx_state_t    seg_next;

    // Frame content is built from latched fields only, so inputs may change mid-frame.
    always_comb begin
        eth_hdr = {op_reply ? mac_q : 48'hFFFF_FFFF_FFFF, BOARD_MAC, ETH_TYPE_ARP};
        arp_pl  = {ARP_HTYPE, ARP_PTYPE, ARP_HLEN, ARP_PLEN,
                   op_reply ? ARP_OP_REPLY : ARP_OP_REQ,
                   BOARD_MAC, BOARD_IP,
                   op_reply ? mac_q : 48'h0, ip_q};
        for (int i = 0; i < ETH_HEAD_LEN; i++) begin
            eth_bytes[i] = eth_hdr[8*(ETH_HEAD_LEN-1-i) +: 8];
        end
        for (int i = 0; i < ARP_DATA_LEN; i++) begin
            arp_bytes[i] = arp_pl[8*(ARP_DATA_LEN-1-i) +: 8];
        end
    end

    always_comb begin
        fcs      = ~crc_out;
        cur_byte = 8'h00;
        seg_last = 7'd0;
        seg_next = ST_IDLE;
        case (state)
            ST_ETH_HEAD: begin
                cur_byte = eth_bytes[cnt[3:0]];
                seg_last = last_idx(ETH_HEAD_LEN);
                seg_next = ST_ARP_DATA;
            end
            ST_ARP_DATA: begin
                cur_byte = arp_bytes[cnt[4:0]];
                seg_last = last_idx(ARP_DATA_LEN);
                seg_next = ST_PAD;
            end
            ST_PAD: begin
                cur_byte = 8'h00;
                seg_last = last_idx(PAD_LEN);
                seg_next = ST_FCS;
            end
            ST_FCS: begin
                cur_byte = fcs[{cnt[1:0], 3'b000} +: 8];
                seg_last = last_idx(FCS_LEN);
                seg_next = ST_IFG;
            end
            default: begin
                cur_byte = 8'h00;
                seg_last = 7'd0;
                seg_next = ST_IDLE;
            end
        endcase
    end

    assign crc_en  = (state == ST_ETH_HEAD) || (state == ST_ARP_DATA) || (state == ST_PAD);
    assign crc_clr = (state == ST_IDLE) && arp_tx_en;

    crc32_d8 u_crc (
        .clk     (clk),
        .rst_n   (rst_n),
        .crc_en  (crc_en),
        .crc_clr (crc_clr),
        .data    (cur_byte),
        .crc_out (crc_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= 7'd0;
            op_reply   <= 1'b0;
            mac_q      <= 48'h0;
            ip_q       <= 32'h0;
            gmii_tx_en <= 1'b0;
            gmii_txd   <= 8'h00;
            tx_done    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    gmii_tx_en <= 1'b0;
                    gmii_txd   <= 8'h00;
                    busy       <= 1'b0;
                    if (arp_tx_en) begin
                        op_reply <= arp_tx_type;
                        mac_q    <= des_mac;
                        ip_q     <= des_ip;
                        cnt      <= 7'd0;
                        state    <= ST_PREAMBLE;
                    end
                end
                ST_PREAMBLE: begin
                    busy       <= 1'b1;
                    gmii_tx_en <= 1'b1;
                    if (cnt == last_idx(PREAMBLE_LEN)) begin
                        gmii_txd <= SFD_BYTE;
                        cnt      <= 7'd0;
                        state    <= ST_ETH_HEAD;
                    end else begin
                        gmii_txd <= PREAMBLE_BYTE;
                        cnt      <= cnt + 7'd1;
                    end
                end
                ST_ETH_HEAD, ST_ARP_DATA, ST_PAD, ST_FCS: begin
                    gmii_tx_en <= 1'b1;
                    gmii_txd   <= cur_byte;
                    if (cnt == seg_last) begin
                        cnt   <= 7'd0;
                        state <= seg_next;
                    end else begin
                        cnt <= cnt + 7'd1;
                    end
                end
                ST_IFG: begin
                    gmii_tx_en <= 1'b0;
                    gmii_txd   <= 8'h00;
                    tx_done    <= (cnt == 7'd0);
                    // busy drops with the return to IDLE so a start is taken in that cycle.
                    if (cnt == last_idx(IFG_CYCLES)) begin
                        cnt   <= 7'd0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 7'd1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    cnt        <= 7'd0;
                    gmii_tx_en <= 1'b0;
                    gmii_txd   <= 8'h00;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arp_tx.sv
// Self-checking bench for arp_tx: frames are compared byte-for-byte against a
// byte-list model of an Ethernet II / ARP frame with a software CRC-32.
module tb_arp_tx;

    localparam logic [47:0] MAC = 48'h00_11_22_33_44_55;
    localparam logic [31:0] IP  = {8'd192, 8'd168, 8'd1, 8'd10};
    localparam int          IFG = 12;
    localparam int          FRAME_LEN = 72;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        arp_tx_en = 1'b0;
    logic        arp_tx_type = 1'b0;
    logic [47:0] des_mac = 48'h0;
    logic [31:0] des_ip = 32'h0;
    logic        gmii_tx_en;
    logic [7:0]  gmii_txd;
    logic        tx_done;
    logic        busy;

    logic        c_en = 1'b0;
    logic        c_clr = 1'b0;
    logic [7:0]  c_data = 8'h00;
    logic [31:0] c_out;

    int n_checks = 0;
    int n_pass = 0;

    logic [7:0]  cap_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_body[$];
    logic [31:0] exp_fcs;
    int          n_done;
    int          idle_bad;
    bit          lat_ok;
    bit          timed_out;

    always #4 clk = ~clk;

    arp_tx #(.BOARD_MAC(MAC), .BOARD_IP(IP), .IFG_CYCLES(IFG)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .arp_tx_en   (arp_tx_en),
        .arp_tx_type (arp_tx_type),
        .des_mac     (des_mac),
        .des_ip      (des_ip),
        .gmii_tx_en  (gmii_tx_en),
        .gmii_txd    (gmii_txd),
        .tx_done     (tx_done),
        .busy        (busy)
    );

    crc32_d8 u_crc (
        .clk     (clk),
        .rst_n   (rst_n),
        .crc_en  (c_en),
        .crc_clr (c_clr),
        .data    (c_data),
        .crc_out (c_out)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r = c;
        for (int b = 0; b < 8; b++) begin
            if (r[0] ^ d[b]) r = (r >> 1) ^ 32'hEDB8_8320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    task automatic push_be(input logic [47:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) exp_body.push_back(v[8*i +: 8]);
    endtask

    task automatic build_expected(input bit rep, input logic [47:0] mac, input logic [31:0] ip);
        logic [31:0] crc;
        exp_body = {};
        push_be(rep ? mac : 48'hFFFF_FFFF_FFFF, 6);
        push_be(MAC, 6);
        push_be(48'h0806, 2);
        push_be(48'h0001_0800_0604, 6);
        push_be(rep ? 48'h0002 : 48'h0001, 2);
        push_be(MAC, 6);
        push_be({16'h0, IP}, 4);
        push_be(rep ? mac : 48'h0, 6);
        push_be({16'h0, ip}, 4);
        while (exp_body.size() < 60) exp_body.push_back(8'h00);
        crc = 32'hFFFF_FFFF;
        foreach (exp_body[i]) crc = crc_step(crc, exp_body[i]);
        exp_fcs = ~crc;
        exp_q = {};
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        foreach (exp_body[i]) exp_q.push_back(exp_body[i]);
        for (int i = 0; i < 4; i++) exp_q.push_back(exp_fcs[8*i +: 8]);
    endtask

    function automatic logic [47:0] get_be(input int off, input int n);
        logic [47:0] v = '0;
        for (int i = 0; i < n; i++) v = {v[39:0], cap_q[off+i]};
        return v;
    endfunction

    function automatic int first_diff();
        int lim = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        for (int i = 0; i < lim; i++) if (cap_q[i] !== exp_q[i]) return i;
        if (cap_q.size() != exp_q.size()) return lim;
        return -1;
    endfunction

    // Starts a frame at the current negedge and records it until busy drops.
    // pulse_at / ifg_pulse_at give a byte index / IFG cycle for a stray start pulse (-1 = none).
    task automatic start_and_capture(input bit rep, input logic [47:0] mac, input logic [31:0] ip,
                                     input int pulse_at, input int ifg_pulse_at);
        int cyc;
        arp_tx_type = rep; des_mac = mac; des_ip = ip; arp_tx_en = 1'b1;
        @(negedge clk);
        arp_tx_en = 1'b0;
        arp_tx_type = ~rep; des_mac = {16'($urandom), $urandom}; des_ip = $urandom;
        lat_ok = (gmii_tx_en === 1'b0) && (busy === 1'b0);
        @(negedge clk);
        lat_ok = lat_ok && (gmii_tx_en === 1'b1) && (gmii_txd === 8'h55) && (busy === 1'b1);
        cap_q = {}; n_done = 0; idle_bad = 0; timed_out = 0; cyc = 0;
        while (gmii_tx_en === 1'b1 && cyc < 200) begin
            arp_tx_en = (cap_q.size() == pulse_at);
            cap_q.push_back(gmii_txd);
            if (tx_done === 1'b1) n_done++;
            @(negedge clk);
            cyc++;
        end
        cyc = 0;
        while (busy === 1'b1 && cyc < 50) begin
            arp_tx_en = (cyc == ifg_pulse_at);
            if (tx_done === 1'b1) n_done++;
            if (gmii_tx_en !== 1'b0 || gmii_txd !== 8'h00) idle_bad++;
            @(negedge clk);
            cyc++;
        end
        arp_tx_en = 1'b0;
        if (cyc >= 50 || cap_q.size() >= 200) timed_out = 1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (gmii_tx_en !== 1'b0 || gmii_txd !== 8'h00) $display("FAIL reset_gmii: got en=%b txd=%h want en=0 txd=00", gmii_tx_en, gmii_txd);
        else n_pass++;
        n_checks++;
        if (tx_done !== 1'b0 || busy !== 1'b0) $display("FAIL reset_flags: got done=%b busy=%b want 0 0", tx_done, busy);
        else n_pass++;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (gmii_tx_en !== 1'b0 || busy !== 1'b0 || tx_done !== 1'b0) $display("FAIL idle_after_reset: got en=%b busy=%b done=%b want 0 0 0", gmii_tx_en, busy, tx_done);
        else n_pass++;
    endtask

    task automatic test_crc_standalone();
        string s = "123456789";
        @(negedge clk); c_clr = 1'b1;
        @(negedge clk); c_clr = 1'b0;
        n_checks++;
        if (c_out !== 32'hFFFF_FFFF) $display("FAIL crc_preset: got %h want ffffffff", c_out);
        else n_pass++;
        c_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            c_data = s[i];
            @(negedge clk);
        end
        c_en = 1'b0;
        n_checks++;
        if (~c_out !== 32'hCBF4_3926) $display("FAIL crc_check_value: got %h want cbf43926", ~c_out);
        else n_pass++;
    endtask

    task automatic test_request();
        logic [31:0] ip = {8'd192, 8'd168, 8'd1, 8'd102};
        int fd;
        build_expected(1'b0, 48'hDEAD_BEEF_0001, ip);
        start_and_capture(1'b0, 48'hDEAD_BEEF_0001, ip, -1, -1);
        fd = first_diff();
        n_checks++;
        if (lat_ok !== 1'b1) $display("FAIL req_start_latency: got lat_ok=%b want 1", lat_ok);
        else n_pass++;
        n_checks++;
        if (cap_q.size() != FRAME_LEN) $display("FAIL req_length: got %0d want %0d", cap_q.size(), FRAME_LEN);
        else n_pass++;
        n_checks++;
        if (get_be(8, 6) !== 48'hFFFF_FFFF_FFFF) $display("FAIL req_dst_mac: got %h want ffffffffffff", get_be(8, 6));
        else n_pass++;
        n_checks++;
        if (get_be(28, 2) !== 48'h0001 || get_be(40, 6) !== 48'h0 || get_be(46, 4) !== 48'hC0A8_0166)
            $display("FAIL req_fields: got op=%h tha=%h tpa=%h want 0001 0 c0a80166", get_be(28, 2), get_be(40, 6), get_be(46, 4));
        else n_pass++;
        n_checks++;
        if ({cap_q[71], cap_q[70], cap_q[69], cap_q[68]} !== exp_fcs)
            $display("FAIL req_fcs: got %h want %h", {cap_q[71], cap_q[70], cap_q[69], cap_q[68]}, exp_fcs);
        else n_pass++;
        n_checks++;
        if (fd != -1) $display("FAIL req_frame: first differing byte %0d got %h want %h", fd, cap_q[fd], exp_q[fd]);
        else n_pass++;
        n_checks++;
        if (n_done != 1 || idle_bad != 0 || timed_out) $display("FAIL req_tail: got done=%0d idle_bad=%0d timeout=%0d want 1 0 0", n_done, idle_bad, timed_out);
        else n_pass++;
    endtask

    task automatic test_reply();
        logic [47:0] mac = 48'hA0B1_C2D3_E4F5;
        logic [31:0] ip = $urandom;
        int fd;
        int pad_bad = 0;
        build_expected(1'b1, mac, ip);
        start_and_capture(1'b1, mac, ip, -1, -1);
        fd = first_diff();
        for (int i = 50; i < 68; i++) if (cap_q[i] !== 8'h00) pad_bad++;
        n_checks++;
        if (get_be(8, 6) !== mac || get_be(40, 6) !== mac) $display("FAIL rep_macs: got dst=%h tha=%h want %h", get_be(8, 6), get_be(40, 6), mac);
        else n_pass++;
        n_checks++;
        if (get_be(28, 2) !== 48'h0002 || get_be(36, 4) !== 48'hC0A8_010A) $display("FAIL rep_op_spa: got op=%h spa=%h want 0002 c0a8010a", get_be(28, 2), get_be(36, 4));
        else n_pass++;
        n_checks++;
        if (pad_bad != 0) $display("FAIL rep_pad: got %0d nonzero pad bytes want 0", pad_bad);
        else n_pass++;
        n_checks++;
        if (fd != -1 || cap_q.size() != FRAME_LEN) $display("FAIL rep_frame: first diff %0d len %0d want -1 len %0d", fd, cap_q.size(), FRAME_LEN);
        else n_pass++;
        n_checks++;
        if (lat_ok !== 1'b1 || n_done != 1 || idle_bad != 0 || timed_out) $display("FAIL rep_timing: got lat=%b done=%0d idle_bad=%0d timeout=%0d want 1 1 0 0", lat_ok, n_done, idle_bad, timed_out);
        else n_pass++;
    endtask

    task automatic test_random_frames();
        for (int k = 0; k < 4; k++) begin
            bit          rep = 1'($urandom);
            logic [47:0] mac = {16'($urandom), $urandom};
            logic [31:0] ip = $urandom;
            int fd;
            build_expected(rep, mac, ip);
            start_and_capture(rep, mac, ip, -1, -1);
            fd = first_diff();
            n_checks++;
            if (fd != -1) $display("FAIL rand_frame%0d: first diff %0d len %0d want -1 len %0d", k, fd, cap_q.size(), FRAME_LEN);
            else n_pass++;
            n_checks++;
            if (lat_ok !== 1'b1 || n_done != 1 || idle_bad != 0 || timed_out) $display("FAIL rand_timing%0d: got lat=%b done=%0d idle_bad=%0d timeout=%0d want 1 1 0 0", k, lat_ok, n_done, idle_bad, timed_out);
            else n_pass++;
        end
    endtask

    task automatic test_ignore_while_busy();
        logic [31:0] ip = $urandom;
        logic [31:0] ip2 = $urandom;
        int fd;
        build_expected(1'b0, 48'h0, ip);
        start_and_capture(1'b0, 48'h0, ip, 30, 4);
        fd = first_diff();
        n_checks++;
        if (fd != -1) $display("FAIL ignore_frame: first diff %0d len %0d want -1 len %0d", fd, cap_q.size(), FRAME_LEN);
        else n_pass++;
        n_checks++;
        if (n_done != 1 || timed_out) $display("FAIL ignore_done_count: got %0d timeout=%0d want 1 0", n_done, timed_out);
        else n_pass++;
        // busy was just seen low: a start now must be taken immediately.
        build_expected(1'b1, 48'h0102_0304_0506, ip2);
        start_and_capture(1'b1, 48'h0102_0304_0506, ip2, -1, -1);
        fd = first_diff();
        n_checks++;
        if (lat_ok !== 1'b1) $display("FAIL accept_on_busy_fall: got lat_ok=%b want 1", lat_ok);
        else n_pass++;
        n_checks++;
        if (fd != -1 || n_done != 1) $display("FAIL accept_frame: first diff %0d done %0d want -1 1", fd, n_done);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [47:0] mac_a = {16'($urandom), $urandom};
        logic [31:0] ip_a = $urandom;
        logic [47:0] mac_b = {16'($urandom), $urandom};
        logic [31:0] ip_b = $urandom;
        logic [7:0]  exp_a[$];
        logic [7:0]  exp_b[$];
        logic [7:0]  got[2][$];
        int          start_cyc[2];
        int          nfr = 0;
        int          dn = 0;
        bit          prev_en = 1'b0;
        bit          fin = 1'b0;
        int          bad_a = 0;
        int          bad_b = 0;
        build_expected(1'b1, mac_a, ip_a); exp_a = exp_q;
        build_expected(1'b0, mac_b, ip_b); exp_b = exp_q;
        start_cyc[0] = -1; start_cyc[1] = -1;
        arp_tx_type = 1'b1; des_mac = mac_a; des_ip = ip_a; arp_tx_en = 1'b1;
        for (int c = 0; c < 400 && !fin; c++) begin
            @(negedge clk);
            if (gmii_tx_en === 1'b1 && !prev_en) begin
                if (nfr < 2) start_cyc[nfr] = c;
                nfr++;
            end
            if (gmii_tx_en === 1'b1 && nfr >= 1 && nfr <= 2) got[nfr-1].push_back(gmii_txd);
            if (tx_done === 1'b1) begin
                dn++;
                if (dn == 1) begin arp_tx_type = 1'b0; des_mac = mac_b; des_ip = ip_b; end
                if (dn == 2) begin arp_tx_en = 1'b0; fin = 1'b1; end
            end
            prev_en = (gmii_tx_en === 1'b1);
        end
        arp_tx_en = 1'b0;
        for (int c = 0; c < 50 && busy !== 1'b0; c++) @(negedge clk);
        if (got[0].size() != exp_a.size()) bad_a++;
        else foreach (exp_a[i]) if (got[0][i] !== exp_a[i]) bad_a++;
        if (got[1].size() != exp_b.size()) bad_b++;
        else foreach (exp_b[i]) if (got[1][i] !== exp_b[i]) bad_b++;
        n_checks++;
        if (!fin || nfr != 2) $display("FAIL b2b_frames: got %0d frames fin=%0d want 2 fin=1", nfr, fin);
        else n_pass++;
        n_checks++;
        if (start_cyc[1] - start_cyc[0] != 1 + FRAME_LEN + IFG) $display("FAIL b2b_spacing: got %0d want %0d", start_cyc[1] - start_cyc[0], 1 + FRAME_LEN + IFG);
        else n_pass++;
        n_checks++;
        if (bad_a != 0 || bad_b != 0) $display("FAIL b2b_content: got bad bytes a=%0d b=%0d (len %0d %0d) want 0 0", bad_a, bad_b, got[0].size(), got[1].size());
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL b2b_busy_release: got busy=%b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int nbytes = 0;
        int stray = 0;
        logic [31:0] ip = $urandom;
        int fd;
        arp_tx_type = 1'b1; des_mac = 48'h1111_2222_3333; des_ip = ip; arp_tx_en = 1'b1;
        @(negedge clk);
        arp_tx_en = 1'b0;
        for (int c = 0; c < 100 && nbytes < 41; c++) begin
            @(negedge clk);
            if (gmii_tx_en === 1'b1) nbytes++;
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (gmii_tx_en !== 1'b0 || gmii_txd !== 8'h00 || busy !== 1'b0 || tx_done !== 1'b0)
            $display("FAIL reset_mid_immediate: got en=%b txd=%h busy=%b done=%b want 0 00 0 0", gmii_tx_en, gmii_txd, busy, tx_done);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (tx_done !== 1'b0 || gmii_tx_en !== 1'b0) stray++;
        end
        n_checks++;
        if (stray != 0) $display("FAIL reset_mid_quiet: got %0d active cycles want 0", stray);
        else n_pass++;
        build_expected(1'b0, 48'h0, ip);
        start_and_capture(1'b0, 48'h0, ip, -1, -1);
        fd = first_diff();
        n_checks++;
        if (fd != -1 || n_done != 1 || lat_ok !== 1'b1) $display("FAIL reset_mid_next_frame: first diff %0d len %0d done %0d lat %b want -1 72 1 1", fd, cap_q.size(), n_done, lat_ok);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_crc_standalone();
        test_request();
        test_reply();
        test_random_frames();
        test_ignore_while_busy();
        test_back_to_back();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
